tap_ctrl: RTL and testbench

IEEE 1149.1-style TAP controller and instruction register that sequence the JTAG data-register block. Decodes TMS into the 16-state TAP FSM, holds a 4-bit instruction register, and drives the DR block's capture/shift/update strobes and one-hot instruction selects. Also multiplexes the scan-chain outputs onto TDO, and provides the bypass cell and a BIST run strobe.

---
 rtl/tap_ctrl.sv | 178 +++++++++++++++++
 tb/tb_tap_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tap_ctrl.sv
// rtl/tap_ctrl.sv - IEEE 1149.1 TAP FSM, 4-bit IR, DR strobes and TDO mux; TAP_RUNBIST_EN enables RUNBIST
module tap_ctrl (
    input  logic       TCK,
    input  logic       RST,
    input  logic       TMS,
    input  logic       TDI,
    input  logic       ID_REG_TDO,
    input  logic       BSR_TDO,
    input  logic       BIST_TDO,
    output logic       CAPTUREDR,
    output logic       SHIFTDR,
    output logic       UPDATEDR,
    output logic       IDCODE_SELECT,
    output logic       SAMPLE_SELECT,
    output logic       EXTEST_SELECT,
    output logic       INTEST_SELECT,
    output logic       USERCODE_SELECT,
    output logic       RUNBIST_SELECT,
    output logic       GETTEST_SELECT,
    output logic       BIST_RUN,
    output logic       TDO,
    output logic       TDO_EN,
    output logic [3:0] TAP_STATE
);

    localparam logic [3:0] S_TLR  = 4'hF;
    localparam logic [3:0] S_RTI  = 4'hC;
    localparam logic [3:0] S_SDRS = 4'h7;
    localparam logic [3:0] S_CDR  = 4'h6;
    localparam logic [3:0] S_SDR  = 4'h2;
    localparam logic [3:0] S_E1DR = 4'h1;
    localparam logic [3:0] S_PDR  = 4'h3;
    localparam logic [3:0] S_E2DR = 4'h0;
    localparam logic [3:0] S_UDR  = 4'h5;
    localparam logic [3:0] S_SIRS = 4'h4;
    localparam logic [3:0] S_CIR  = 4'hE;
    localparam logic [3:0] S_SIR  = 4'hA;
    localparam logic [3:0] S_E1IR = 4'h9;
    localparam logic [3:0] S_PIR  = 4'hB;
    localparam logic [3:0] S_E2IR = 4'h8;
    localparam logic [3:0] S_UIR  = 4'hD;

    localparam logic [3:0] OP_EXTEST   = 4'h0;
    localparam logic [3:0] OP_IDCODE   = 4'h1;
    localparam logic [3:0] OP_SAMPLE   = 4'h2;
    localparam logic [3:0] OP_INTEST   = 4'h3;
    localparam logic [3:0] OP_USERCODE = 4'h4;
    localparam logic [3:0] OP_GETTEST  = 4'h6;
`ifdef TAP_RUNBIST_EN
    localparam logic [3:0] OP_RUNBIST  = 4'h5;
`endif

    localparam logic [3:0] IR_CAPTURE  = 4'b0101;

    logic [3:0] state;
    logic [3:0] next_state;
    logic [3:0] ir;
    logic [3:0] ir_sh;
    logic       bypass_reg;
    logic       any_select;
    logic       bsr_select;
    logic       tdo_next;

`ifndef TAP_RUNBIST_EN
    logic       bist_tdo_unused;
    assign bist_tdo_unused = BIST_TDO;
`endif

    always_ff @(posedge TCK) begin
        if (RST) begin
            state <= S_TLR;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_TLR:   next_state = TMS ? S_TLR  : S_RTI;
            S_RTI:   next_state = TMS ? S_SDRS : S_RTI;
            S_SDRS:  next_state = TMS ? S_SIRS : S_CDR;
            S_CDR:   next_state = TMS ? S_E1DR : S_SDR;
            S_SDR:   next_state = TMS ? S_E1DR : S_SDR;
            S_E1DR:  next_state = TMS ? S_UDR  : S_PDR;
            S_PDR:   next_state = TMS ? S_E2DR : S_PDR;
            S_E2DR:  next_state = TMS ? S_UDR  : S_SDR;
            S_UDR:   next_state = TMS ? S_SDRS : S_RTI;
            S_SIRS:  next_state = TMS ? S_TLR  : S_CIR;
            S_CIR:   next_state = TMS ? S_E1IR : S_SIR;
            S_SIR:   next_state = TMS ? S_E1IR : S_SIR;
            S_E1IR:  next_state = TMS ? S_UIR  : S_PIR;
            S_PIR:   next_state = TMS ? S_E2IR : S_PIR;
            S_E2IR:  next_state = TMS ? S_UIR  : S_SIR;
            S_UIR:   next_state = TMS ? S_SDRS : S_RTI;
            default: next_state = S_TLR;
        endcase
    end

    always_comb begin
        CAPTUREDR       = (state == S_CDR);
        SHIFTDR         = (state == S_SDR);
        UPDATEDR        = (state == S_UDR);

        IDCODE_SELECT   = 1'b0;
        SAMPLE_SELECT   = 1'b0;
        EXTEST_SELECT   = 1'b0;
        INTEST_SELECT   = 1'b0;
        USERCODE_SELECT = 1'b0;
        RUNBIST_SELECT  = 1'b0;
        GETTEST_SELECT  = 1'b0;
        // Unlisted opcodes fall through to the all-low BYPASS decode.
        case (ir)
            OP_EXTEST:   EXTEST_SELECT   = 1'b1;
            OP_IDCODE:   IDCODE_SELECT   = 1'b1;
            OP_SAMPLE:   SAMPLE_SELECT   = 1'b1;
            OP_INTEST:   INTEST_SELECT   = 1'b1;
            OP_USERCODE: USERCODE_SELECT = 1'b1;
            OP_GETTEST:  GETTEST_SELECT  = 1'b1;
`ifdef TAP_RUNBIST_EN
            OP_RUNBIST:  RUNBIST_SELECT  = 1'b1;
`endif
            default:     ;
        endcase

        BIST_RUN   = RUNBIST_SELECT && (state == S_RTI);
        bsr_select = SAMPLE_SELECT | EXTEST_SELECT | INTEST_SELECT |
                     USERCODE_SELECT | GETTEST_SELECT;
        any_select = bsr_select | IDCODE_SELECT | RUNBIST_SELECT;

        tdo_next = 1'b0;
        if (state == S_SIR) begin
            tdo_next = ir_sh[0];
        end else if (state == S_SDR) begin
            if (IDCODE_SELECT) begin
                tdo_next = ID_REG_TDO;
            end else if (bsr_select) begin
                tdo_next = BSR_TDO;
`ifdef TAP_RUNBIST_EN
            end else if (RUNBIST_SELECT) begin
                tdo_next = BIST_TDO;
`endif
            end else begin
                tdo_next = bypass_reg;
            end
        end
    end

    // Each action lands on the posedge that ends the state it belongs to.
    always_ff @(posedge TCK) begin
        if (RST || (state == S_TLR)) begin
            ir         <= OP_IDCODE;
            ir_sh      <= 4'b0000;
            bypass_reg <= 1'b0;
        end else begin
            case (state)
                S_CIR:   ir_sh <= IR_CAPTURE;
                S_SIR:   ir_sh <= {TDI, ir_sh[3:1]};
                S_UIR:   ir    <= ir_sh;
                S_CDR:   bypass_reg <= 1'b0;
                S_SDR: begin
                    if (!any_select) begin
                        bypass_reg <= TDI;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(negedge TCK) begin
        TDO    <= tdo_next;
        TDO_EN <= (state == S_SIR) || (state == S_SDR);
    end

    assign TAP_STATE = state;

endmodule

// File: tb/tb_tap_ctrl.sv
// tb/tb_tap_ctrl.sv - directed table-driven bench for tap_ctrl
module tb_tap_ctrl;

    logic       TCK = 1'b0;
    logic       RST = 1'b1;
    logic       TMS = 1'b0;
    logic       TDI = 1'b0;
    logic       ID_REG_TDO = 1'b0;
    logic       BSR_TDO = 1'b0;
    logic       BIST_TDO = 1'b0;
    logic       CAPTUREDR, SHIFTDR, UPDATEDR;
    logic       IDCODE_SELECT, SAMPLE_SELECT, EXTEST_SELECT, INTEST_SELECT;
    logic       USERCODE_SELECT, RUNBIST_SELECT, GETTEST_SELECT;
    logic       BIST_RUN, TDO, TDO_EN;
    logic [3:0] TAP_STATE;

    tap_ctrl dut (
        .TCK(TCK), .RST(RST), .TMS(TMS), .TDI(TDI),
        .ID_REG_TDO(ID_REG_TDO), .BSR_TDO(BSR_TDO), .BIST_TDO(BIST_TDO),
        .CAPTUREDR(CAPTUREDR), .SHIFTDR(SHIFTDR), .UPDATEDR(UPDATEDR),
        .IDCODE_SELECT(IDCODE_SELECT), .SAMPLE_SELECT(SAMPLE_SELECT),
        .EXTEST_SELECT(EXTEST_SELECT), .INTEST_SELECT(INTEST_SELECT),
        .USERCODE_SELECT(USERCODE_SELECT), .RUNBIST_SELECT(RUNBIST_SELECT),
        .GETTEST_SELECT(GETTEST_SELECT), .BIST_RUN(BIST_RUN),
        .TDO(TDO), .TDO_EN(TDO_EN), .TAP_STATE(TAP_STATE)
    );

    always #5 TCK = ~TCK;

    typedef struct {
        logic [3:0] from;
        logic [7:0] path;
        int         len;
        logic       tms;
        logic [3:0] exp;
    } vec_t;

    vec_t vt[32];
    int   nv = 0;
    int   tests = 0;
    int   fails = 0;
    int   cap_c, sh_c, upd_c, en_c;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] f, input logic [7:0] p, input int l,
                       input logic t, input logic [3:0] e);
        vt[nv].from = f; vt[nv].path = p; vt[nv].len = l;
        vt[nv].tms = t; vt[nv].exp = e;
        nv++;
    endtask

    task automatic tick(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge TCK);
        #1;
    endtask

    function automatic logic [6:0] sels();
        return {IDCODE_SELECT, SAMPLE_SELECT, EXTEST_SELECT, INTEST_SELECT,
                USERCODE_SELECT, RUNBIST_SELECT, GETTEST_SELECT};
    endfunction

    // Path bits are applied left to right as written: p[len-1] first.
    task automatic goto_state(input logic [7:0] p, input int l);
        RST = 1'b1;
        tick(1'b0, 1'b0);
        RST = 1'b0;
        for (int i = l - 1; i >= 0; i--) tick(p[i], 1'b0);
    endtask

    task automatic sample_dr();
        @(negedge TCK);
        #1;
        cap_c += int'(CAPTUREDR);
        sh_c  += int'(SHIFTDR);
        upd_c += int'(UPDATEDR);
        en_c  += int'(TDO_EN);
    endtask

    // Starts and ends in RTI.
    task automatic ir_scan(input logic [3:0] val, output logic [3:0] tdo_v, output logic [3:0] en_v);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge TCK);
            #1;
            tdo_v[i] = TDO;
            en_v[i]  = TDO_EN;
            tick(i == 3, val[i]);
        end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic dr_scan(input int n, input logic [15:0] tdi_v, input logic [15:0] id_v,
                           input logic [15:0] bsr_v, input logic [15:0] bist_v,
                           output logic [15:0] tdo_v);
        tdo_v = 16'h0;
        cap_c = 0; sh_c = 0; upd_c = 0; en_c = 0;
        tick(1'b1, 1'b0);
        sample_dr();
        tick(1'b0, 1'b0);
        sample_dr();
        tick(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            ID_REG_TDO = id_v[i];
            BSR_TDO    = bsr_v[i];
            BIST_TDO   = bist_v[i];
            sample_dr();
            tdo_v[i] = TDO;
            tick(i == n - 1, tdi_v[i]);
        end
        ID_REG_TDO = 1'b0; BSR_TDO = 1'b0; BIST_TDO = 1'b0;
        sample_dr();
        tick(1'b1, 1'b0);
        sample_dr();
        tick(1'b0, 1'b0);
        sample_dr();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0]  ir_tdo, ir_en;
        logic [15:0] dr_tdo;

        add(4'hF, 8'b0,       0, 1'b0, 4'hC); add(4'hF, 8'b0,       0, 1'b1, 4'hF);
        add(4'hC, 8'b0,       1, 1'b0, 4'hC); add(4'hC, 8'b0,       1, 1'b1, 4'h7);
        add(4'h7, 8'b01,      2, 1'b0, 4'h6); add(4'h7, 8'b01,      2, 1'b1, 4'h4);
        add(4'h6, 8'b010,     3, 1'b0, 4'h2); add(4'h6, 8'b010,     3, 1'b1, 4'h1);
        add(4'h2, 8'b0100,    4, 1'b0, 4'h2); add(4'h2, 8'b0100,    4, 1'b1, 4'h1);
        add(4'h1, 8'b0101,    4, 1'b0, 4'h3); add(4'h1, 8'b0101,    4, 1'b1, 4'h5);
        add(4'h3, 8'b01010,   5, 1'b0, 4'h3); add(4'h3, 8'b01010,   5, 1'b1, 4'h0);
        add(4'h0, 8'b010101,  6, 1'b0, 4'h2); add(4'h0, 8'b010101,  6, 1'b1, 4'h5);
        add(4'h5, 8'b01011,   5, 1'b0, 4'hC); add(4'h5, 8'b01011,   5, 1'b1, 4'h7);
        add(4'h4, 8'b011,     3, 1'b0, 4'hE); add(4'h4, 8'b011,     3, 1'b1, 4'hF);
        add(4'hE, 8'b0110,    4, 1'b0, 4'hA); add(4'hE, 8'b0110,    4, 1'b1, 4'h9);
        add(4'hA, 8'b01100,   5, 1'b0, 4'hA); add(4'hA, 8'b01100,   5, 1'b1, 4'h9);
        add(4'h9, 8'b01101,   5, 1'b0, 4'hB); add(4'h9, 8'b01101,   5, 1'b1, 4'hD);
        add(4'hB, 8'b011010,  6, 1'b0, 4'hB); add(4'hB, 8'b011010,  6, 1'b1, 4'h8);
        add(4'h8, 8'b0110101, 7, 1'b0, 4'hA); add(4'h8, 8'b0110101, 7, 1'b1, 4'hD);
        add(4'hD, 8'b011011,  6, 1'b0, 4'hC); add(4'hD, 8'b011011,  6, 1'b1, 4'h7);

        // Reset values
        RST = 1'b1;
        tick(1'b0, 1'b0);
        chk("rst_state", 32'(TAP_STATE), 32'hF);
        chk("rst_sels", 32'(sels()), 32'h40);
        chk("rst_strobes", 32'({CAPTUREDR, SHIFTDR, UPDATEDR, BIST_RUN}), 32'h0);
        @(negedge TCK);
        #1;
        chk("rst_tdo", 32'({TDO, TDO_EN}), 32'h0);

        // RST from the middle of a DR shift, dominating TMS
        RST = 1'b0;
        tick(1'b0, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        chk("in_shdr", 32'(TAP_STATE), 32'h2);
        RST = 1'b1;
        tick(1'b1, 1'b0);
        chk("rst_shdr_state", 32'(TAP_STATE), 32'hF);
        chk("rst_shdr_sels", 32'(sels()), 32'h40);
        chk("rst_shdr_strobes", 32'({CAPTUREDR, SHIFTDR, UPDATEDR}), 32'h0);
        RST = 1'b0;
        tick(1'b0, 1'b0);
        chk("rst_then_rti", 32'(TAP_STATE), 32'hC);

        // Full transition table, plus five TMS=1 to TLR from every state
        for (int i = 0; i < nv; i++) begin
            goto_state(vt[i].path, vt[i].len);
            chk($sformatf("reach_%0h", vt[i].from), 32'(TAP_STATE), 32'(vt[i].from));
            tick(vt[i].tms, 1'b0);
            chk($sformatf("next_%0h_tms%0d", vt[i].from, vt[i].tms), 32'(TAP_STATE), 32'(vt[i].exp));
            if (vt[i].tms) begin
                repeat (4) tick(1'b1, 1'b0);
                chk($sformatf("tlr5_from_%0h", vt[i].from), 32'(TAP_STATE), 32'hF);
            end
        end

        // IR scan of USERCODE: capture pattern 0101 appears LSB-first
        goto_state(8'b0, 1);
        ir_scan(4'h4, ir_tdo, ir_en);
        chk("ir_capture_tdo", 32'(ir_tdo), 32'h5);
        chk("ir_tdo_en", 32'(ir_en), 32'hF);
        chk("usercode_sels", 32'(sels()), 32'h04);
        chk("usercode_in_rti", 32'(TAP_STATE), 32'hC);

        // BYPASS: one-cycle delay through the bypass cell
        ir_scan(4'hF, ir_tdo, ir_en);
        chk("bypass_sels", 32'(sels()), 32'h00);
        dr_scan(4, 16'h000D, 16'h000F, 16'h000F, 16'h000F, dr_tdo);
        chk("bypass_tdo", 32'(dr_tdo[3:0]), 32'hA);
        chk("bypass_en_cnt", 32'(en_c), 32'd4);
        chk("bypass_sh_cnt", 32'(sh_c), 32'd4);

        // Pause holds the bypass cell; no strobes in Ex1/Pause/Ex2
        tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        chk("ex1dr_strobes", 32'({CAPTUREDR, SHIFTDR, UPDATEDR}), 32'h0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("pausedr_state", 32'(TAP_STATE), 32'h3);
        chk("pausedr_strobes", 32'({CAPTUREDR, SHIFTDR, UPDATEDR}), 32'h0);
        tick(1'b1, 1'b0);
        chk("ex2dr_strobes", 32'({CAPTUREDR, SHIFTDR, UPDATEDR}), 32'h0);
        tick(1'b0, 1'b0);
        @(negedge TCK);
        #1;
        chk("pause_held_tdo", 32'({TDO, TDO_EN}), 32'h3);
        tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0);

        // IDCODE DR scan of 8 bits
        ir_scan(4'h1, ir_tdo, ir_en);
        chk("idcode_sels", 32'(sels()), 32'h40);
        dr_scan(8, 16'h0000, 16'h00A1, 16'h005E, 16'h005E, dr_tdo);
        chk("idcode_tdo", 32'(dr_tdo[7:0]), 32'hA1);
        chk("idcode_sh_cnt", 32'(sh_c), 32'd8);
        chk("idcode_cap_cnt", 32'(cap_c), 32'd1);
        chk("idcode_upd_cnt", 32'(upd_c), 32'd1);
        chk("idcode_en_cnt", 32'(en_c), 32'd8);

        // SAMPLE routes BSR_TDO
        ir_scan(4'h2, ir_tdo, ir_en);
        chk("sample_sels", 32'(sels()), 32'h20);
        dr_scan(4, 16'h0000, 16'h0009, 16'h0006, 16'h0009, dr_tdo);
        chk("sample_tdo", 32'(dr_tdo[3:0]), 32'h6);

        // RUNBIST (opcode 5)
        ir_scan(4'h5, ir_tdo, ir_en);
`ifdef TAP_RUNBIST_EN
        chk("runbist_sels", 32'(sels()), 32'h02);
        chk("bist_run_rti", 32'(BIST_RUN), 32'h1);
        dr_scan(4, 16'h000D, 16'h0000, 16'h0000, 16'h0003, dr_tdo);
        chk("runbist_tdo", 32'(dr_tdo[3:0]), 32'h3);
`else
        chk("runbist_sels", 32'(sels()), 32'h00);
        chk("bist_run_rti", 32'(BIST_RUN), 32'h0);
        dr_scan(4, 16'h000D, 16'h0000, 16'h0000, 16'h0003, dr_tdo);
        chk("runbist_tdo", 32'(dr_tdo[3:0]), 32'hA);
`endif
        chk("bist_run_after_scan", 32'(BIST_RUN), 32'(RUNBIST_SELECT));

        // Unlisted opcode decodes as BYPASS
        ir_scan(4'h7, ir_tdo, ir_en);
        chk("op7_sels", 32'(sels()), 32'h00);

        // RST during an IR shift leaves IR at IDCODE
        tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        tick(1'b0, 1'b1); tick(1'b0, 1'b1);
        RST = 1'b1;
        tick(1'b0, 1'b0);
        RST = 1'b0;
        chk("abort_ir_state", 32'(TAP_STATE), 32'hF);
        chk("abort_ir_sels", 32'(sels()), 32'h40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
